// File: rtl/fdma_wr_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fdma_wr_feeder: stream-to-FDMA write feeder with a show-ahead FIFO; issues  |
// | full/partial write requests. Optional stats: define FDMA_WR_STAT_EN.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fdma_wr_feeder #(
  parameter int DATA_WIDTH = 512,
  parameter int REQ_LEN    = 256,
  parameter int FIFO_DEPTH = 512
) (
  input  logic                         M_AXI_ACLK,
  input  logic                         M_AXI_ARESET,
  input  logic [DATA_WIDTH-1:0]        i_data,
  input  logic                         i_valid,
  input  logic                         i_sof,
  input  logic                         i_eof,
  output logic                         o_ready,
  output logic                         fdma_wareq,
  output logic [15:0]                  fdma_wlen,
  output logic [DATA_WIDTH-1:0]        fdma_wdata,
  output logic [DATA_WIDTH/8-1:0]      fdma_wstrb,
  output logic                         fdma_wready,
  input  logic                         fdma_wvalid,
  input  logic                         fdma_wbusy,
  output logic                         o_ddr_addr_rst,
`ifdef FDMA_WR_STAT_EN
  output logic [31:0]                  o_req_cnt,
  output logic [15:0]                  o_frame_cnt,
  output logic                         o_stall,
`endif
  output logic [$clog2(FIFO_DEPTH):0]  o_fifo_cnt
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0] c_depth   = c_cw'(FIFO_DEPTH);
  localparam logic [c_cw-1:0] c_req_len = c_cw'(REQ_LEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [c_aw-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cw-1:0] cnt_q, cnt_d;
  logic [1:0]      state_q, state_d;
  logic            wareq_q, wareq_d;
  logic [15:0]     wlen_q, wlen_d;
  logic            flush_pending_q, flush_pending_d;
  logic            ddr_addr_rst_q, ddr_addr_rst_d;

  logic w_full, w_empty, w_sof_hold, w_push, w_pop, w_launch;

  assign w_full     = (cnt_q == c_depth);
  assign w_empty    = (cnt_q == '0);
  // A new frame may only enter once the previous one has fully drained.
  assign w_sof_hold = i_sof && !((state_q == S_IDLE) && w_empty);
  assign o_ready    = !w_full && !w_sof_hold;
  assign w_push     = i_valid && o_ready;
  assign w_pop      = fdma_wvalid && !w_empty;

  always_ff @(posedge M_AXI_ACLK) begin
    if (w_push) mem_q[wr_ptr_q] <= i_data;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({w_push, w_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State register
  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q         <= S_IDLE;
      wareq_q         <= 1'b0;
      wlen_q          <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      cnt_q           <= '0;
      flush_pending_q <= 1'b0;
      ddr_addr_rst_q  <= 1'b1;
    end else begin
      state_q         <= state_d;
      wareq_q         <= wareq_d;
      wlen_q          <= wlen_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      cnt_q           <= cnt_d;
      flush_pending_q <= flush_pending_d;
      ddr_addr_rst_q  <= ddr_addr_rst_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    w_launch = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((cnt_q >= c_req_len) || (flush_pending_q && !w_empty)) begin
          w_launch = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ:   if (fdma_wbusy)  state_d = S_BUSY;
      S_BUSY:  if (!fdma_wbusy) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    wareq_d         = wareq_q;
    wlen_d          = wlen_q;
    flush_pending_d = flush_pending_q;
    ddr_addr_rst_d  = !(w_push && i_sof);
    if (w_launch) begin
      wareq_d = 1'b1;
      // Full-length requests win over a pending flush.
      wlen_d  = (cnt_q >= c_req_len) ? 16'(REQ_LEN) : 16'(cnt_q);
      if ((cnt_q - c_cw'(wlen_d)) == '0) flush_pending_d = 1'b0;
    end else if ((state_q == S_REQ) && fdma_wbusy) begin
      wareq_d = 1'b0;
    end
    // An end-of-frame beat arriving alongside a launch belongs to later data.
    if (w_push && i_eof) flush_pending_d = 1'b1;
  end

  assign fdma_wareq     = wareq_q;
  assign fdma_wlen      = wlen_q;
  assign fdma_wdata     = mem_q[rd_ptr_q];
  assign fdma_wstrb     = '1;
  assign fdma_wready    = !w_empty;
  assign o_ddr_addr_rst = ddr_addr_rst_q;
  assign o_fifo_cnt     = cnt_q;

`ifdef FDMA_WR_STAT_EN
  logic [31:0] req_cnt_q, req_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        stall_q, stall_d;

  always_comb begin
    req_cnt_d   = req_cnt_q + (w_launch ? 32'd1 : 32'd0);
    frame_cnt_d = frame_cnt_q + ((w_push && i_sof) ? 16'd1 : 16'd0);
    stall_d     = i_valid && !o_ready;
  end

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      req_cnt_q   <= '0;
      frame_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      req_cnt_q   <= req_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      stall_q     <= stall_d;
    end
  end

  assign o_req_cnt   = req_cnt_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_stall     = stall_q;
`endif

endmodule
`default_nettype wire
